seq_multiplier: RTL

//  Parametrised iterative shift-add multiplier, signed/unsigned selectable per transaction.

---
 rtl/seq_multiplier_pkg.sv | 20 ++
 rtl/seq_multiplier_twos_abs.sv | 27 ++
 rtl/seq_multiplier.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// ----------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the iterative shift-add multiplier:
//   state_t        FSM state encodings (IDLE=0, BUSY=1, DONE=2)
//   cnt_width()    width of the iteration counter for a given multiplier width
// ----------------------------------------------------------------------------
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // The counter must be able to hold WIDTH_B itself, hence the +1
   function automatic int cnt_width(input int width_b);
      return $clog2(width_b + 1);
   endfunction

endpackage

// File: rtl/seq_multiplier_twos_abs.sv
// ----------------------------------------------------------------------------
// twos_abs
// Converts an operand to magnitude + sign so the multiplier core only ever
// works on unsigned values.
// Ports:
//   value      in   W   operand as presented on the input bus
//   is_signed  in   1   1 = treat value as two's complement
//   magnitude  out  W   |value| as a W-bit unsigned number
//   sign       out  1   1 = value was negative (only possible when is_signed)
// ----------------------------------------------------------------------------
module twos_abs #(
   parameter int W = 5
) (
   input  logic [W-1:0] value,
   input  logic         is_signed,
   output logic [W-1:0] magnitude,
   output logic         sign
);

   // The most negative value negates to itself, which read back as unsigned
   // is exactly its magnitude (e.g. 5'b10000 -> 16), so no extra bit is needed
   always_comb begin
      sign      = is_signed & value[W-1];
      magnitude = sign ? (~value + W'(1)) : value;
   end

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, one multiplier bit per clock, with
// per-transaction signed/unsigned selection and valid/ready on both sides.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        block can accept operands (IDLE only)
//   in_signed  in   1        1 = operands are two's complement
//   a          in   WIDTH_A  multiplicand
//   b          in   WIDTH_B  multiplier
//   out_valid  out  1        res holds a finished product
//   out_ready  in   1        downstream accepts res
//   res        out  WIDTH_P  full-width product
// ----------------------------------------------------------------------------
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter  int WIDTH_A = 5,
   parameter  int WIDTH_B = 5,
   localparam int WIDTH_P = WIDTH_A + WIDTH_B
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH_A-1:0] a,
   input  logic [WIDTH_B-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_P-1:0] res
);

   localparam int CNT_W = cnt_width(WIDTH_B);

   state_t             state;
   logic [WIDTH_A-1:0] ma;
   logic [WIDTH_B-1:0] mb;
   logic [WIDTH_P-1:0] acc;
   logic [CNT_W-1:0]   cnt;
   logic               neg;

   logic [WIDTH_A-1:0] mag_a;
   logic [WIDTH_B-1:0] mag_b;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH_P-1:0] addend;
   logic [WIDTH_P-1:0] acc_sum;
   logic               last_step;

   twos_abs #(.W(WIDTH_A)) abs_a (
      .value     (a),
      .is_signed (in_signed),
      .magnitude (mag_a),
      .sign      (sign_a)
   );

   twos_abs #(.W(WIDTH_B)) abs_b (
      .value     (b),
      .is_signed (in_signed),
      .magnitude (mag_b),
      .sign      (sign_b)
   );

   // Partial product for this step: the multiplicand weighted by the bit
   // position currently sitting in mb[0]; the final sum is needed on the last
   // edge so the result register can be loaded in the same cycle
   always_comb begin
      addend    = WIDTH_P'(ma) << cnt;
      acc_sum   = mb[0] ? (acc + addend) : acc;
      last_step = (cnt == CNT_W'(WIDTH_B - 1));
   end

   // Control FSM and datapath together. in_ready/out_valid are registered
   // alongside the state so they are glitch-free decodes of it. The sign
   // is applied once at the end; a zero magnitude negates to zero, so a
   // "negative zero" cannot appear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         res       <= '0;
         ma        <= '0;
         mb        <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  ma       <= mag_a;
                  mb       <= mag_b;
                  neg      <= sign_a ^ sign_b;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc <= acc_sum;
               mb  <= mb >> 1;
               cnt <= cnt + CNT_W'(1);
               if (last_step) begin
                  res       <= neg ? (~acc_sum + WIDTH_P'(1)) : acc_sum;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
